data_path: RTL and testbench
============================

# data_path

Single-bus 32-bit processor datapath: sixteen general registers, HI/LO, PC, IR, MAR, MDR, Y, 64-bit Z, in-port register, ALU and a 512×32 internal RAM, all joined by one multiplexed 32-bit bus. It sits under the control unit, which drives the one-hot bus-select and register-enable vectors, the IR-field select/encode strobes, memory strobes and the ALU opcode. Register contents are exported for observation.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state updates on rising edge
- `clr`  in  1  reset, synchronous, active-high
- `enable`  in  32  one-hot register load strobes: [15:0] R0–R15, 16 HI, 17 LO, 18 Z, 19 Y, 20 PC, 21 MDR, 24 IR, 25 MAR; others ignored
- `busSelect`  in  32  bus source selects: [15:0] R0–R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C (sign-extended IR constant); others ignored
- `inPort`  in  32  external input data
- `MD_Read`  in  1  MDR input mux: 1 = RAM data, 0 = bus
- `Gra`, `Grb`, `Grc`  in  1 each  select IR field ra/rb/rc as register number
- `Rin`, `Rout`, `BAout`  in  1 each  load / drive selected register; BAout drives it but R0 reads as 0
- `WriteRAM`, `ReadRAM`  in  1 each  memory write / read enable
- `Control_Signals`  in  5  ALU opcode
- `busMuxOut`  out  32  current bus value
- `r1`, `r2`, `r3`, `mdr`, `zhi`, `zlo`, `pc`, `ir`  out  32 each  register contents

## Operation
- IR fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15], C = sign-extend IR[18:0].
- Select/encode: register number = ra if Gra, else rb if Grb, else rc if Grc, else 0. Rin asserts that register's load; Rout/BAout assert its bus select. These OR into `enable[15:0]`/`busSelect[15:0]`.
- Bus: lowest-indexed asserted select wins; none asserted → 0. Source R0 with BAout → 0.
- ALU: A = Y, B = bus; 64-bit result to Z (ZHI = [63:32], ZLO = [31:0]). Unused high half = 0 except MUL/DIV.
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL (shift amount B[4:0]), 9 NEG B, 10 NOT B, 11 MUL signed (64-bit), 12 DIV signed (ZLO quotient, ZHI remainder; B = 0 → Z = 0), 13 pass B, 14 INC (B+1), 15–31 → 0. Adds wrap mod 2^32.
- MDR loads RAM[MAR[8:0]] if MD_Read, else bus, when `enable[21]`.
- RAM read is combinational when ReadRAM; data 0 when ReadRAM low. WriteRAM writes MDR to RAM[MAR[8:0]] on rising edge.
- InPort register captures `inPort` every clock.
- R0 is a normal storage register; only BAout forces 0.

## Timing
- All register loads on rising `clk` with enable high; bus and ALU combinational, so a value driven and loaded in the same cycle appears in the destination after that edge.
- Read-before-write: the same register as source and destination loads its old value's result.
- `clr`: on the edge, all registers (R0–R15, HI, LO, Y, Z, PC, IR, MAR, MDR, InPort) → 0; all outputs read 0 afterward. `clr` overrides simultaneous loads. RAM contents not reset; write suppressed during `clr`.
- Simultaneous WriteRAM and MDR read of same address: read returns old data.

## Configuration
- `DATAPATH_MULDIV_EN`: defined → opcodes 11/12 implement MUL/DIV as above. Undefined → opcodes 11/12 produce Z = 0 and no multiplier/divider is synthesised.

## Test plan
- Reset: load several registers, pulse `clr` one cycle → r1,r2,r3,mdr,zhi,zlo,pc,ir all 0.
- PC increment: pc = 0, busSelect[20] + enable[18] + opcode 14 → zlo = 1; next cycle busSelect[19] + enable[20] → pc = 1.
- Memory: inPort = 0x12345678, busSelect[22] + enable[21] → mdr; inPort = 5 → MAR; WriteRAM; load MDR = 0; ReadRAM + MD_Read + enable[21] → mdr = 0x12345678.
- Fetch: RAM[1] = 0x00800000, MAR = 1, read into MDR, busSelect[21] + enable[24] → ir = 0x00800000; Gra + Rin with inPort = 7 on bus → r1 = 7.
- ALU: Y = 7, bus = 5, opcode 0 → zlo = 12; opcode 1 → zlo = 2; opcode 9 → zlo = 0xFFFFFFFB.
- MUL (macro on): Y = 0xFFFFFFFF, bus = 2, opcode 11 → zhi = 0xFFFFFFFF, zlo = 0xFFFFFFFE; macro off → zhi = zlo = 0.

Source files
------------

// File: rtl/data_path.sv
// data_path: single-bus 32-bit processor datapath.
// Sixteen general registers, HI/LO, PC, IR, MAR, MDR, Y, 64-bit Z, an in-port
// register, the ALU and a 512x32 RAM all share one 32-bit bus driven by a
// priority mux. The control unit drives the select/enable vectors and strobes.
// Optional feature macro: DATAPATH_MULDIV_EN (adds signed MUL/DIV, opcodes 11/12).
module data_path (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] enable,
  input  logic [31:0] busSelect,
  input  logic [31:0] inPort,
  input  logic        MD_Read,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        WriteRAM,
  input  logic        ReadRAM,
  input  logic [4:0]  Control_Signals,
  output logic [31:0] busMuxOut,
  output logic [31:0] r1,
  output logic [31:0] r2,
  output logic [31:0] r3,
  output logic [31:0] mdr,
  output logic [31:0] zhi,
  output logic [31:0] zlo,
  output logic [31:0] pc,
  output logic [31:0] ir
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_SHR  = 5'd4,  OP_SHRA = 5'd5,  OP_SHL  = 5'd6,  OP_ROR  = 5'd7,
    OP_ROL  = 5'd8,  OP_NEG  = 5'd9,  OP_NOT  = 5'd10, OP_MUL  = 5'd11,
    OP_DIV  = 5'd12, OP_PASS = 5'd13, OP_INC  = 5'd14
  } alu_op_e;

  logic [31:0] regs_q [16];
  logic [31:0] hi_q, lo_q, y_q, pc_q, ir_q, mar_q, mdr_q, inport_q;
  logic [63:0] z_q, z_d;
  logic [31:0] mdr_d;
  logic [31:0] ram_q [512];
  logic [31:0] ram_rdata;

  logic [31:0] bus;
  logic [31:0] bus_src [24];
  logic [23:0] bus_sel;
  logic [15:0] reg_load;
  logic [15:0] reg_onehot;
  logic [3:0]  reg_num;
  logic [31:0] c_sext;

  // IR field select: ra has priority over rb, rb over rc; none selects R0.
  always_comb begin
    reg_num = 4'd0;
    if (Gra)      reg_num = ir_q[26:23];
    else if (Grb) reg_num = ir_q[22:19];
    else if (Grc) reg_num = ir_q[18:15];
  end

  assign reg_onehot = 16'd1 << reg_num;
  assign reg_load   = enable[15:0] | (Rin ? reg_onehot : 16'd0);
  assign bus_sel    = {busSelect[23:16],
                       busSelect[15:0] | ((Rout || BAout) ? reg_onehot : 16'd0)};
  assign c_sext     = {{13{ir_q[18]}}, ir_q[18:0]};

  // Gather every bus source; R0 reads as zero when it is the BAout target.
  always_comb begin
    for (int i = 0; i < 16; i++) bus_src[i] = regs_q[i];
    if (BAout && reg_num == 4'd0) bus_src[0] = '0;
    bus_src[16] = hi_q;
    bus_src[17] = lo_q;
    bus_src[18] = z_q[63:32];
    bus_src[19] = z_q[31:0];
    bus_src[20] = pc_q;
    bus_src[21] = mdr_q;
    bus_src[22] = inport_q;
    bus_src[23] = c_sext;
  end

  // Priority bus mux: scanning downward lets the lowest asserted select win.
  always_comb begin
    // NOTE: default assignment first so every path assigns bus and no latch is inferred.
    bus = '0;
    for (int i = 23; i >= 0; i--) begin
      if (bus_sel[i]) bus = bus_src[i];
    end
  end

  // ALU: A = Y, B = bus, 64-bit result destined for Z.
  logic [4:0]  shamt;
  logic [63:0] rot_dbl, ror_full, rol_full;
  assign shamt    = bus[4:0];
  assign rot_dbl  = {y_q, y_q};
  assign ror_full = rot_dbl >> shamt;
  assign rol_full = rot_dbl << shamt;

`ifdef DATAPATH_MULDIV_EN
  logic signed [63:0] mul_a, mul_b, mul_prod;
  logic signed [31:0] div_a, div_b, div_quo, div_rem;
  assign mul_a    = {{32{y_q[31]}}, y_q};
  assign mul_b    = {{32{bus[31]}}, bus};
  assign mul_prod = mul_a * mul_b;
  assign div_a    = y_q;
  assign div_b    = bus;
  assign div_quo  = (bus != 32'd0) ? div_a / div_b : 32'sd0;
  assign div_rem  = (bus != 32'd0) ? div_a % div_b : 32'sd0;
`endif

  // Opcode decode; unused high half and undefined opcodes yield zero.
  always_comb begin
    z_d = '0;
    case (Control_Signals)
      OP_ADD:  z_d[31:0] = y_q + bus;
      OP_SUB:  z_d[31:0] = y_q - bus;
      OP_AND:  z_d[31:0] = y_q & bus;
      OP_OR:   z_d[31:0] = y_q | bus;
      OP_SHR:  z_d[31:0] = y_q >> shamt;
      OP_SHRA: z_d[31:0] = $signed(y_q) >>> shamt;
      OP_SHL:  z_d[31:0] = y_q << shamt;
      OP_ROR:  z_d[31:0] = ror_full[31:0];
      OP_ROL:  z_d[31:0] = rol_full[63:32];
      OP_NEG:  z_d[31:0] = ~bus + 32'd1;
      OP_NOT:  z_d[31:0] = ~bus;
`ifdef DATAPATH_MULDIV_EN
      OP_MUL:  z_d = mul_prod;
      OP_DIV:  z_d = {div_rem, div_quo};
`endif
      OP_PASS: z_d[31:0] = bus;
      OP_INC:  z_d[31:0] = bus + 32'd1;
      default: z_d = '0;
    endcase
  end

  // RAM read port is combinational and gated by ReadRAM.
  assign ram_rdata = ReadRAM ? ram_q[mar_q[8:0]] : 32'd0;
  assign mdr_d     = MD_Read ? ram_rdata : bus;

  // Register bank update with synchronous clear overriding all loads.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values (read-before-write).
    if (clr) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      z_q      <= '0;
      y_q      <= '0;
      pc_q     <= '0;
      mdr_q    <= '0;
      ir_q     <= '0;
      mar_q    <= '0;
      inport_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (reg_load[i]) regs_q[i] <= bus;
      end
      if (enable[16]) hi_q  <= bus;
      if (enable[17]) lo_q  <= bus;
      if (enable[18]) z_q   <= z_d;
      if (enable[19]) y_q   <= bus;
      if (enable[20]) pc_q  <= bus;
      if (enable[21]) mdr_q <= mdr_d;
      if (enable[24]) ir_q  <= bus;
      if (enable[25]) mar_q <= bus;
      inport_q <= inPort;
    end
  end

  // RAM write port; writes are held off while clr is asserted.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array is deliberately not reset; only its write is gated by clr.
    if (WriteRAM && !clr) ram_q[mar_q[8:0]] <= mdr_q;
  end

  // Bits of the control vectors and registers that this datapath does not consume.
  logic unused_bits;
  assign unused_bits = ^{enable[31:26], enable[23:22], busSelect[31:24],
                         ir_q[31:27], mar_q[31:9]};

  assign busMuxOut = bus;
  assign r1  = regs_q[1];
  assign r2  = regs_q[2];
  assign r3  = regs_q[3];
  assign mdr = mdr_q;
  assign zhi = z_q[63:32];
  assign zlo = z_q[31:0];
  assign pc  = pc_q;
  assign ir  = ir_q;

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: self-checking bench for data_path. ALU behaviour is driven
// from a vector table through a scoreboard queue; register, bus, memory and
// reset corner cases are covered by short hand-written sequences.
module tb_data_path;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] enable, busSelect, inPort;
  logic        MD_Read, Gra, Grb, Grc, Rin, Rout, BAout, WriteRAM, ReadRAM;
  logic [4:0]  Control_Signals;
  logic [31:0] busMuxOut, r1, r2, r3, mdr, zhi, zlo, pc, ir;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] y;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } alu_vec_t;

  alu_vec_t    vecs[$];
  logic [63:0] sb_q[$];

  data_path dut (
    .clk(clk), .clr(clr), .enable(enable), .busSelect(busSelect), .inPort(inPort),
    .MD_Read(MD_Read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .WriteRAM(WriteRAM), .ReadRAM(ReadRAM),
    .Control_Signals(Control_Signals), .busMuxOut(busMuxOut), .r1(r1), .r2(r2),
    .r3(r3), .mdr(mdr), .zhi(zhi), .zlo(zlo), .pc(pc), .ir(ir)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    enable = '0; busSelect = '0; MD_Read = 0; Gra = 0; Grb = 0; Grc = 0;
    Rin = 0; Rout = 0; BAout = 0; WriteRAM = 0; ReadRAM = 0; Control_Signals = '0;
  endtask

  // The in-port register lags the pin by one clock, so capture first.
  task automatic set_inport(input logic [31:0] v);
    inPort = v;
    cyc();
  endtask

  task automatic load_from_inport(input int bit_idx, input logic [31:0] v);
    set_inport(v);
    busSelect = 32'd1 << 22;
    enable    = 32'd1 << bit_idx;
    cyc();
    clear_ctl();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_r1"},  r1,  32'd0);
    check({tag, "_r2"},  r2,  32'd0);
    check({tag, "_r3"},  r3,  32'd0);
    check({tag, "_mdr"}, mdr, 32'd0);
    check({tag, "_zhi"}, zhi, 32'd0);
    check({tag, "_zlo"}, zlo, 32'd0);
    check({tag, "_pc"},  pc,  32'd0);
    check({tag, "_ir"},  ir,  32'd0);
  endtask

  initial begin
    logic [63:0] exp_z;

    vecs.push_back('{5'd0,  32'h0000_0007, 32'h0000_0005, 32'h0, 32'h0000_000C});
    vecs.push_back('{5'd1,  32'h0000_0007, 32'h0000_0005, 32'h0, 32'h0000_0002});
    vecs.push_back('{5'd9,  32'h0000_0007, 32'h0000_0005, 32'h0, 32'hFFFF_FFFB});
    vecs.push_back('{5'd0,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0000_0001});
    vecs.push_back('{5'd2,  32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0000_F000});
    vecs.push_back('{5'd3,  32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0000_FFF0});
    vecs.push_back('{5'd4,  32'h8000_0000, 32'h0000_0004, 32'h0, 32'h0800_0000});
    vecs.push_back('{5'd5,  32'h8000_0000, 32'h0000_0004, 32'h0, 32'hF800_0000});
    vecs.push_back('{5'd6,  32'h8000_0001, 32'h0000_0001, 32'h0, 32'h0000_0002});
    vecs.push_back('{5'd7,  32'h0000_0001, 32'h0000_0001, 32'h0, 32'h8000_0000});
    vecs.push_back('{5'd8,  32'h8000_0000, 32'h0000_0001, 32'h0, 32'h0000_0001});
    vecs.push_back('{5'd8,  32'h1234_5678, 32'h0000_0020, 32'h0, 32'h1234_5678});
    vecs.push_back('{5'd10, 32'h0000_0000, 32'h0F0F_0F0F, 32'h0, 32'hF0F0_F0F0});
    vecs.push_back('{5'd13, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF});
    vecs.push_back('{5'd14, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000});
`ifdef DATAPATH_MULDIV_EN
    vecs.push_back('{5'd11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{5'd12, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{5'd12, 32'h0000_0064, 32'h0000_0000, 32'h0, 32'h0});
`else
    vecs.push_back('{5'd11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0});
    vecs.push_back('{5'd12, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0, 32'h0});
`endif
    vecs.push_back('{5'd13, 32'h0, 32'hABCD_0123, 32'h0, 32'hABCD_0123});
    vecs.push_back('{5'd15, 32'h0000_0003, 32'h0000_0004, 32'h0, 32'h0});
    vecs.push_back('{5'd31, 32'h0000_0003, 32'h0000_0004, 32'h0, 32'h0});

    clear_ctl();
    inPort = '0;
    clr = 1'b1;
    cyc();
    cyc();
    clr = 1'b0;
    check_all_zero("reset");
    check("reset_bus_idle", busMuxOut, 32'd0);

    // Load several registers, then clear with conflicting loads asserted.
    load_from_inport(1,  32'hAAAA_0001);
    load_from_inport(2,  32'hAAAA_0002);
    load_from_inport(3,  32'hAAAA_0003);
    load_from_inport(20, 32'hAAAA_0020);
    load_from_inport(24, 32'hAAAA_0024);
    load_from_inport(21, 32'hAAAA_0021);
    check("preclr_r2", r2, 32'hAAAA_0002);
    check("preclr_ir", ir, 32'hAAAA_0024);
    busSelect = 32'd1 << 22;
    enable    = (32'd1 << 1) | (32'd1 << 18) | (32'd1 << 20) | (32'd1 << 21) | (32'd1 << 24);
    Control_Signals = 5'd13;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    clear_ctl();
    check_all_zero("clr");
    busSelect = 32'd1 << 22;
    #1;
    check("clr_inport_reg", busMuxOut, 32'd0);
    clear_ctl();

    // PC increment via Z, then Z read-before-write.
    busSelect = 32'd1 << 20; enable = 32'd1 << 18; Control_Signals = 5'd14;
    cyc(); clear_ctl();
    check("pcinc_zlo", zlo, 32'd1);
    busSelect = 32'd1 << 19; enable = 32'd1 << 20;
    cyc(); clear_ctl();
    check("pcinc_pc", pc, 32'd1);
    busSelect = 32'd1 << 19; enable = 32'd1 << 18; Control_Signals = 5'd14;
    cyc(); clear_ctl();
    check("z_self_inc", zlo, 32'd2);

    // Memory write then read back through MDR.
    load_from_inport(21, 32'h1234_5678);
    check("mem_mdr_bus", mdr, 32'h1234_5678);
    load_from_inport(25, 32'd5);
    WriteRAM = 1; cyc(); clear_ctl();
    load_from_inport(21, 32'd0);
    check("mem_mdr_zero", mdr, 32'd0);
    ReadRAM = 1; MD_Read = 1; enable = 32'd1 << 21;
    cyc(); clear_ctl();
    check("mem_readback", mdr, 32'h1234_5678);
    MD_Read = 1; enable = 32'd1 << 21;
    cyc(); clear_ctl();
    check("mem_read_gated", mdr, 32'd0);

    // Simultaneous write and read of one address returns the old word.
    load_from_inport(21, 32'hAAAA_5555);
    WriteRAM = 1; ReadRAM = 1; MD_Read = 1; enable = 32'd1 << 21;
    cyc(); clear_ctl();
    check("mem_rw_old", mdr, 32'h1234_5678);
    ReadRAM = 1; MD_Read = 1; enable = 32'd1 << 21;
    cyc(); clear_ctl();
    check("mem_rw_new", mdr, 32'hAAAA_5555);

    // A write attempted during clr must not land.
    load_from_inport(21, 32'h0000_0001);
    load_from_inport(25, 32'd9);
    WriteRAM = 1; cyc(); clear_ctl();
    load_from_inport(21, 32'h0000_0099);
    WriteRAM = 1; clr = 1'b1; cyc(); clr = 1'b0; clear_ctl();
    load_from_inport(25, 32'd9);
    ReadRAM = 1; MD_Read = 1; enable = 32'd1 << 21;
    cyc(); clear_ctl();
    check("mem_clr_nowrite", mdr, 32'h0000_0001);

    // Fetch an instruction and use its ra field.
    load_from_inport(21, 32'h0080_0000);
    load_from_inport(25, 32'd1);
    WriteRAM = 1; cyc(); clear_ctl();
    load_from_inport(21, 32'd0);
    ReadRAM = 1; MD_Read = 1; enable = 32'd1 << 21;
    cyc(); clear_ctl();
    check("fetch_mdr", mdr, 32'h0080_0000);
    busSelect = 32'd1 << 21; enable = 32'd1 << 24;
    cyc(); clear_ctl();
    check("fetch_ir", ir, 32'h0080_0000);
    set_inport(32'd7);
    busSelect = 32'd1 << 22; Gra = 1; Rin = 1;
    cyc(); clear_ctl();
    check("gra_rin_r1", r1, 32'd7);
    busSelect = (32'd1 << 1) | (32'd1 << 22);
    #1;
    check("bus_priority", busMuxOut, 32'd7);
    clear_ctl();

    // rb and rc selects, and ra priority over rb.
    load_from_inport(24, 32'h0010_0000);
    set_inport(32'h22);
    busSelect = 32'd1 << 22; Grb = 1; Rin = 1;
    cyc(); clear_ctl();
    check("grb_rin_r2", r2, 32'h22);
    load_from_inport(24, 32'h0001_8000);
    set_inport(32'h33);
    busSelect = 32'd1 << 22; Grc = 1; Rin = 1;
    cyc(); clear_ctl();
    check("grc_rin_r3", r3, 32'h33);
    load_from_inport(24, 32'h0190_0000);
    set_inport(32'h44);
    busSelect = 32'd1 << 22; Gra = 1; Grb = 1; Rin = 1;
    cyc(); clear_ctl();
    check("gra_prio_r3", r3, 32'h44);
    check("gra_prio_r2", r2, 32'h22);

    // R0 storage, Rout versus BAout, and the sign-extended constant.
    load_from_inport(0, 32'h55);
    load_from_inport(24, 32'h0);
    Gra = 1; Rout = 1;
    #1;
    check("r0_rout", busMuxOut, 32'h55);
    Rout = 0; BAout = 1;
    #1;
    check("r0_baout", busMuxOut, 32'h0);
    clear_ctl();
    load_from_inport(24, 32'h0004_0001);
    busSelect = 32'd1 << 23;
    #1;
    check("c_sext", busMuxOut, 32'hFFFC_0001);
    clear_ctl();

    // Table-driven ALU vectors through the scoreboard.
    foreach (vecs[i]) begin
      load_from_inport(19, vecs[i].y);
      set_inport(vecs[i].b);
      busSelect = 32'd1 << 22; enable = 32'd1 << 18; Control_Signals = vecs[i].op;
      sb_q.push_back({vecs[i].hi, vecs[i].lo});
      cyc(); clear_ctl();
      exp_z = sb_q.pop_front();
      check($sformatf("alu%0d_op%0d_zhi", i, vecs[i].op), zhi, exp_z[63:32]);
      check($sformatf("alu%0d_op%0d_zlo", i, vecs[i].op), zlo, exp_z[31:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
